// File: rtl/erc_mult_pipe_pkg.sv
// Shared constants, stage payload type and K/column-mask helpers for the
// error-configurable approximate multiplier.
package erc_mult_pkg;

    localparam int MIN_WIDTH  = 4;
    localparam int MAX_WIDTH  = 16;
    localparam int PIPE_DEPTH = 3;
    localparam int KMAX_W     = $clog2(2 * MAX_WIDTH) + 1;

    typedef logic [KMAX_W-1:0] k_t;

    // Operands are stored at the widest legal size; a narrower build uses the low bits.
    typedef struct packed {
        logic                 valid;
        k_t                   k;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

    function automatic k_t clamp_k(input k_t lvl, input int width);
        k_t kmax;
        kmax = k_t'(2 * width);
        return (lvl > kmax) ? kmax : lvl;
    endfunction

    // Bit c set means column c belongs to the OR-compressed low field.
    function automatic logic [2*MAX_WIDTH-1:0] col_mask(input k_t k);
        logic [2*MAX_WIDTH-1:0] m;
        m = '0;
        for (int c = 0; c < 2 * MAX_WIDTH; c++) begin
            m[c] = (c < int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/erc_mult_pipe_if.sv
// Operand/result stream bundle: producer drives operands, consumer drives out_ready.
interface erc_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(2 * WIDTH) + 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     dat_in_a;
    logic [WIDTH-1:0]     dat_in_b;
    logic [LVL_W-1:0]     apx_lvl;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   dat_o;

    modport master (
        output in_valid, dat_in_a, dat_in_b, apx_lvl, out_ready,
        input  in_ready, out_valid, dat_o
    );

    modport slave (
        input  in_valid, dat_in_a, dat_in_b, apx_lvl, out_ready,
        output in_ready, out_valid, dat_o
    );
endinterface

// File: rtl/erc_col_compress.sv
// Column compressor: OR-reduces the low K columns and folds the remaining
// partial products into a carry-save pair.
module erc_col_compress
    import erc_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0][WIDTH-1:0] pp_i,
    input  k_t                          k_i,
    output logic [2*WIDTH-1:0]          low_o,
    output logic [2*WIDTH-1:0]          sum_o,
    output logic [2*WIDTH-1:0]          carry_o
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] mask;

    assign mask = PW'(col_mask(k_i));

    // Row i carries pp(i,j) at column i+j; each row is added with a 3:2 step.
    // Carries leaving the MSB are dropped: the true high sum always fits PW bits.
    always_comb begin
        logic [PW-1:0] row;
        logic [PW-1:0] s_nx;
        low_o   = '0;
        sum_o   = '0;
        carry_o = '0;
        row     = '0;
        s_nx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (mask[i+j]) begin
                    low_o[i+j] = low_o[i+j] | pp_i[i][j];
                end else begin
                    row[i+j] = pp_i[i][j];
                end
            end
            s_nx    = sum_o ^ carry_o ^ row;
            carry_o = ((sum_o & carry_o) | (sum_o & row) | (carry_o & row)) << 1;
            sum_o   = s_nx;
        end
    end

endmodule

// File: rtl/erc_mult_pipe.sv
// Three-stage approximate unsigned multiplier with valid/ready stream.
// Define ERC_MULT_ERR_STAT_EN to add the inexact-result counter (stat_clr/err_cnt).
module erc_mult_pipe
    import erc_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(2 * WIDTH) + 1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    erc_mult_pipe_if.slave    bus
`ifdef ERC_MULT_ERR_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  err_cnt
`endif
);
    localparam int PW = 2 * WIDTH;

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH % 2) != 0 || CNT_W < 1) begin : g_bad_param
        $error("erc_mult_pipe: unsupported WIDTH/CNT_W");
    end

    stage_t                     s1_q;
    stage_t                     s2_q;
    logic [WIDTH-1:0][WIDTH-1:0] pp_d;
    logic [WIDTH-1:0][WIDTH-1:0] pp_q;
    logic [PW-1:0]              low_d;
    logic [PW-1:0]              sum_d;
    logic [PW-1:0]              carry_d;
    logic [PW-1:0]              low_q;
    logic [PW-1:0]              sum_q;
    logic [PW-1:0]              carry_q;
    logic [PW-1:0]              dat_d;
    logic [PW-1:0]              dat_q;
    logic                       out_valid_q;
    logic                       adv;
    k_t                         k_in;
    logic                       unused_payload;

    // Whole pipe moves together; bubbles are kept, only a full output stalls.
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.dat_o     = dat_q;

    assign k_in = clamp_k(KMAX_W'(bus.apx_lvl), WIDTH);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        assign pp_d[gi] = bus.dat_in_b & {WIDTH{bus.dat_in_a[gi]}};
    end

    erc_col_compress #(
        .WIDTH (WIDTH)
    ) u_compress (
        .pp_i    (pp_q),
        .k_i     (s1_q.k),
        .low_o   (low_d),
        .sum_o   (sum_d),
        .carry_o (carry_d)
    );

    // High field is a multiple of 2^K and the low field sits below K, so no overlap.
    assign dat_d = (sum_q + carry_q) + low_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            pp_q        <= '0;
            low_q       <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
            dat_q       <= '0;
        end else if (adv) begin
            s1_q.valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q.k <= k_in;
                s1_q.a <= MAX_WIDTH'(bus.dat_in_a);
                s1_q.b <= MAX_WIDTH'(bus.dat_in_b);
                pp_q   <= pp_d;
            end
            s2_q.valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_q.k  <= s1_q.k;
                s2_q.a  <= s1_q.a;
                s2_q.b  <= s1_q.b;
                low_q   <= low_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
            out_valid_q <= s2_q.valid;
            if (s2_q.valid) begin
                dat_q <= dat_d;
            end
        end
    end

    assign unused_payload = ^{s2_q.k, s2_q.a, s2_q.b};

`ifdef ERC_MULT_ERR_STAT_EN
    logic [PW-1:0]    exact_d;
    logic             inexact_q;
    logic [CNT_W-1:0] err_cnt_q;

    assign exact_d = PW'(s2_q.a[WIDTH-1:0]) * PW'(s2_q.b[WIDTH-1:0]);

    // inexact_q travels with dat_q; the count moves only when the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inexact_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (adv && s2_q.valid) begin
                inexact_q <= (dat_d != exact_d);
            end
            if (stat_clr) begin
                err_cnt_q <= '0;
            end else if (out_valid_q && bus.out_ready && inexact_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_erc_mult_pipe.sv
// Directed scoreboard bench for erc_mult_pipe (WIDTH=8); stat checks
// are compiled in when ERC_MULT_ERR_STAT_EN is defined.
module tb_erc_mult_pipe;
    import erc_mult_pkg::*;

    localparam int W  = 8;
    localparam int LW = $clog2(2 * W) + 1;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           inexact;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    erc_mult_pipe_if #(.WIDTH(W), .LVL_W(LW)) bus ();

`ifdef ERC_MULT_ERR_STAT_EN
    logic        stat_clr;
    logic [15:0] err_cnt;
    int          exp_err;
`endif

    erc_mult_pipe #(
        .WIDTH (W),
        .LVL_W (LW),
        .CNT_W (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ERC_MULT_ERR_STAT_EN
        ,
        .stat_clr (stat_clr),
        .err_cnt  (err_cnt)
`endif
    );

    sb_t         exp_q[$];
    sb_t         pending;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_emit = 0;
    logic        last_acc;
    logic [W-1:0] sa[4];
    logic [W-1:0] sb[4];
    int          sk[4];
    int          idx;
    int          base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    // Reference: OR of each low column, plain weighted sum of the rest.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int           kk;
        logic [2*W-1:0] low;
        int unsigned  hi;
        kk  = (k > 2 * W) ? 2 * W : k;
        low = '0;
        hi  = 0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (a[i] && b[j]) begin
                    if (i + j < kk) low[i+j] = 1'b1;
                    else hi += (32'd1 << (i + j));
                end
            end
        end
        return (2*W)'(hi) | low;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input logic [2*W-1:0] req);
        logic [2*W-1:0] exact;
        bus.in_valid = 1'b1;
        bus.dat_in_a = a;
        bus.dat_in_b = b;
        bus.apx_lvl  = LW'(k);
        exact        = (2*W)'(a) * (2*W)'(b);
        pending      = '{res: req, inexact: (req != exact)};
        $display("drive a=%02h b=%02h k=%0d expect=%04h", a, b, k, req);
    endtask

    task automatic step();
        logic           acc;
        logic           emit;
        logic [2*W-1:0] d;
        sb_t            got;
`ifdef ERC_MULT_ERR_STAT_EN
        logic           clr;
`endif
        @(negedge clk);
        acc  = bus.in_valid && bus.in_ready && rst_n;
        emit = bus.out_valid && bus.out_ready && rst_n;
        d    = bus.dat_o;
`ifdef ERC_MULT_ERR_STAT_EN
        clr  = stat_clr;
`endif
        @(posedge clk);
        #1;
        last_acc = acc;
        if (emit) begin
            n_emit++;
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                $display("emit dat_o=%04h expect=%04h", d, got.res);
                chk("sb_dat_o", 32'(d), 32'(got.res));
`ifdef ERC_MULT_ERR_STAT_EN
                if (got.inexact && exp_err < 65535) exp_err++;
`endif
            end
        end
        if (acc) exp_q.push_back(pending);
`ifdef ERC_MULT_ERR_STAT_EN
        if (clr) exp_err = 0;
`endif
    endtask

    task automatic drain(input string tag);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dat_in_a  = '0;
        bus.dat_in_b  = '0;
        bus.apx_lvl   = '0;
        bus.out_ready = 1'b1;
`ifdef ERC_MULT_ERR_STAT_EN
        stat_clr = 1'b0;
        exp_err  = 0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dat_o", 32'(bus.dat_o), 32'h0000);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ERC_MULT_ERR_STAT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Exact product and its latency: presented in cycle 0, visible in cycle PIPE_DEPTH.
        drive(8'hFF, 8'hFF, 0, 16'hFE01);
        step();
        chk("lat_accept", 32'(last_acc), 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_dat_o", 32'(bus.dat_o), 32'hFE01);
        drain("lat_drain");

        // Approximate beats back to back.
        drive(8'hFF, 8'hFF, 4, 16'hFDDF);
        step();
        chk("apx4_accept", 32'(last_acc), 32'd1);
        drive(8'h03, 8'h03, 16, 16'h0007);
        step();
        chk("apx16_accept", 32'(last_acc), 32'd1);
        drain("apx_drain");
`ifdef ERC_MULT_ERR_STAT_EN
        chk("err_two", 32'(err_cnt), 32'd2);
`endif

        // apx_lvl beyond 2*WIDTH clamps to the full OR compression.
        drive(8'h03, 8'h03, 31, 16'h0007);
        step();
        drain("sat_drain");

`ifdef ERC_MULT_ERR_STAT_EN
        chk("err_model", 32'(err_cnt), 32'(exp_err));
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("err_clr", 32'(err_cnt), 32'd0);
`endif
        drive(8'h5A, 8'h3C, 0, 16'h1518);
        step();
        drain("exact_drain");
`ifdef ERC_MULT_ERR_STAT_EN
        chk("err_exact_unchanged", 32'(err_cnt), 32'd0);
`endif

        // Stall: fill with out_ready low, hold, then release.
        sk[0] = 3; sk[1] = 8; sk[2] = 0; sk[3] = 20;
        for (int i = 0; i < 4; i++) begin
            sa[i] = 8'($urandom_range(0, 255));
            sb[i] = 8'($urandom_range(0, 255));
        end
        bus.out_ready = 1'b0;
        base = n_emit;
        idx  = 0;
        for (int c = 0; c < 3; c++) begin
            drive(sa[idx], sb[idx], sk[idx], model(sa[idx], sb[idx], sk[idx]));
            step();
            if (last_acc) idx++;
        end
        chk("stall_fill", 32'(idx), 32'd3);
        drive(sa[3], sb[3], sk[3], model(sa[3], sb[3], sk[3]));
        for (int c = 0; c < 5; c++) begin
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_hold", 32'(bus.dat_o), 32'(exp_q[0].res));
            step();
            if (last_acc) idx++;
        end
        chk("stall_no_accept", 32'(idx), 32'd3);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step();
            if (last_acc) idx++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd4);
        drain("stall_drain");
        chk("stall_emit_count", 32'(n_emit - base), 32'd4);
`ifdef ERC_MULT_ERR_STAT_EN
        chk("err_after_stall", 32'(err_cnt), 32'(exp_err));
`endif

        // Asynchronous reset with beats in flight discards them all.
        drive(8'h12, 8'h34, 2, model(8'h12, 8'h34, 2));
        step();
        drive(8'hAB, 8'hCD, 6, model(8'hAB, 8'hCD, 6));
        step();
        bus.in_valid = 1'b0;
        step();
        chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_dat_o", 32'(bus.dat_o), 32'h0000);
        exp_q.delete();
`ifdef ERC_MULT_ERR_STAT_EN
        exp_err = 0;
`endif
        base = n_emit;
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("arst_no_output", 32'(n_emit - base), 32'd0);
`ifdef ERC_MULT_ERR_STAT_EN
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
